// File: rtl/uart_dbg_master_if.sv
// rtl/uart_dbg_master_if.sv - UART byte streams, system bus and debug control bundle of the debug bridge
interface uart_dbg_master_if;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_data_ready;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we;
  logic        bus_req;
  logic [7:0]  bus_rdata;
  logic        bus_ack;
  logic        cpu_halt;
  logic        rx_overrun;

  modport master (
    input  rx_data, rx_data_valid, tx_data_ready, bus_rdata, bus_ack,
    output tx_data, tx_data_valid, bus_addr, bus_wdata, bus_we, bus_req,
    output cpu_halt, rx_overrun
  );

  modport slave (
    output rx_data, rx_data_valid, tx_data_ready, bus_rdata, bus_ack,
    input  tx_data, tx_data_valid, bus_addr, bus_wdata, bus_we, bus_req,
    input  cpu_halt, rx_overrun
  );
endinterface

// File: rtl/uart_dbg_master.sv
// rtl/uart_dbg_master.sv - UART byte-command debug bridge driving single-byte bus transactions and CPU halt
module uart_dbg_master #(
  parameter real CLK_FRE        = 25.175,
  parameter int  TIMEOUT_CYCLES = 2500000
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_dbg_master_if.master dbg
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] GET_AH = 3'd1;
  localparam logic [2:0] GET_AL = 3'd2;
  localparam logic [2:0] GET_D  = 3'd3;
  localparam logic [2:0] BUS    = 3'd4;
  localparam logic [2:0] RESP   = 3'd5;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_H = 8'h48;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] RSP_OK  = 8'h2E;
  localparam logic [7:0] RSP_BAD = 8'h3F;

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  if (TIMEOUT_CYCLES < 2 || CLK_FRE <= 0.0) begin : g_param_check
    $error("uart_dbg_master: TIMEOUT_CYCLES must be >= 2 and CLK_FRE positive");
  end

  logic [2:0]    state;
  logic [CW-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      to_cnt            <= '0;
      dbg.tx_data       <= 8'h00;
      dbg.tx_data_valid <= 1'b0;
      dbg.bus_addr      <= 16'h0000;
      dbg.bus_wdata     <= 8'h00;
      dbg.bus_we        <= 1'b0;
      dbg.bus_req       <= 1'b0;
      dbg.cpu_halt      <= 1'b0;
      dbg.rx_overrun    <= 1'b0;
    end else begin
      // Bytes are never queued while a transaction or response is in flight.
      if (dbg.rx_data_valid && (state == BUS || state == RESP))
        dbg.rx_overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (dbg.rx_data_valid) begin
            case (dbg.rx_data)
              CMD_W, CMD_R: begin
                dbg.bus_we <= (dbg.rx_data == CMD_W);
                to_cnt     <= '0;
                state      <= GET_AH;
              end
              CMD_H, CMD_G: begin
                dbg.cpu_halt      <= (dbg.rx_data == CMD_H);
                dbg.tx_data       <= RSP_OK;
                dbg.tx_data_valid <= 1'b1;
                state             <= RESP;
              end
              default: begin
                dbg.tx_data       <= RSP_BAD;
                dbg.tx_data_valid <= 1'b1;
                state             <= RESP;
              end
            endcase
          end
        end

        GET_AH, GET_AL, GET_D: begin
          // A byte landing on the timeout cycle still counts.
          if (dbg.rx_data_valid) begin
            to_cnt <= '0;
            case (state)
              GET_AH: begin
                dbg.bus_addr[15:8] <= dbg.rx_data;
                state              <= GET_AL;
              end
              GET_AL: begin
                dbg.bus_addr[7:0] <= dbg.rx_data;
                if (dbg.bus_we) begin
                  state <= GET_D;
                end else begin
                  dbg.bus_req <= 1'b1;
                  state       <= BUS;
                end
              end
              default: begin
                dbg.bus_wdata <= dbg.rx_data;
                dbg.bus_req   <= 1'b1;
                state         <= BUS;
              end
            endcase
          end else if (to_cnt == TO_LAST) begin
            to_cnt <= '0;
            state  <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        BUS: begin
          if (dbg.bus_ack) begin
            dbg.bus_req       <= 1'b0;
            dbg.tx_data       <= dbg.bus_we ? RSP_OK : dbg.bus_rdata;
            dbg.tx_data_valid <= 1'b1;
            state             <= RESP;
          end
        end

        RESP: begin
          if (dbg.tx_data_ready) begin
            dbg.tx_data_valid <= 1'b0;
            state             <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_dbg_master.sv
// tb/tb_uart_dbg_master.sv - scoreboard bench for the UART debug bridge
module tb_uart_dbg_master;
  localparam logic [7:0] ACK = 8'h2E;
  localparam logic [7:0] NAK = 8'h3F;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_dbg_master_if dbg();

  uart_dbg_master #(.CLK_FRE(25.175), .TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dbg   (dbg)
  );

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    int          delay;
    logic [7:0]  rdata;
  } bus_t;

  bus_t       exp_bus[$];
  logic [7:0] exp_tx[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit resp_pending = 1'b0;

  // Bus responder plus scoreboard: acks after the expected delay and checks each completed
  // transaction and each accepted TX byte against the queued expectations.
  initial begin
    bus_t cur;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (resp_pending) begin
        resp_pending = 1'b0;
        tests++;
        if (dbg.tx_data_valid !== 1'b1 || dbg.bus_req !== 1'b0) begin
          fails++;
          $display("FAIL after_ack: tx_data_valid=%b bus_req=%b, want 1 and 0", dbg.tx_data_valid, dbg.bus_req);
        end
      end
      if (dbg.bus_req === 1'b1) begin
        cyc++;
        if (exp_bus.size() == 0) begin
          dbg.bus_ack = 1'b1;
          dbg.bus_rdata = 8'h00;
          tests++; fails++;
          $display("FAIL unexpected_bus: addr=%h we=%b wdata=%h, want no transaction", dbg.bus_addr, dbg.bus_we, dbg.bus_wdata);
        end else if (cyc == exp_bus[0].delay + 1) begin
          cur = exp_bus.pop_front();
          dbg.bus_ack = 1'b1;
          dbg.bus_rdata = cur.rdata;
          resp_pending = 1'b1;
          tests++;
          if (dbg.bus_addr !== cur.addr || dbg.bus_we !== cur.we || (cur.we && dbg.bus_wdata !== cur.wdata)) begin
            fails++;
            $display("FAIL bus_txn: addr=%h we=%b wdata=%h, want addr=%h we=%b wdata=%h",
                     dbg.bus_addr, dbg.bus_we, dbg.bus_wdata, cur.addr, cur.we, cur.wdata);
          end
        end else begin
          dbg.bus_ack = 1'b0;
        end
      end else begin
        dbg.bus_ack = 1'b0;
        cyc = 0;
      end
      if (dbg.tx_data_valid === 1'b1 && dbg.tx_data_ready === 1'b1) begin
        tests++;
        if (exp_tx.size() == 0) begin
          fails++;
          $display("FAIL unexpected_tx: tx_data=%h, want no response", dbg.tx_data);
        end else begin
          e = exp_tx.pop_front();
          if (dbg.tx_data !== e) begin
            fails++;
            $display("FAIL tx_byte: tx_data=%h, want %h", dbg.tx_data, e);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    dbg.rx_data = b;
    dbg.rx_data_valid = 1'b1;
    @(posedge clk);
    #1;
    dbg.rx_data_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_tx.size() == 0 && exp_bus.size() == 0 && dbg.tx_data_valid === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_drain: %0d bus and %0d tx expectations left, want 0", name, exp_bus.size(), exp_tx.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (dbg.tx_data !== 8'h00 || dbg.tx_data_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_tx: tx_data=%h valid=%b, want 00 0", dbg.tx_data, dbg.tx_data_valid);
    end
    tests++;
    if (dbg.bus_addr !== 16'h0000 || dbg.bus_wdata !== 8'h00 || dbg.bus_we !== 1'b0 || dbg.bus_req !== 1'b0) begin
      fails++;
      $display("FAIL reset_bus: addr=%h wdata=%h we=%b req=%b, want 0000 00 0 0", dbg.bus_addr, dbg.bus_wdata, dbg.bus_we, dbg.bus_req);
    end
    tests++;
    if (dbg.cpu_halt !== 1'b0 || dbg.rx_overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: cpu_halt=%b rx_overrun=%b, want 0 0", dbg.cpu_halt, dbg.rx_overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write();
    exp_bus.push_back('{addr: 16'h1234, we: 1'b1, wdata: 8'hA5, delay: 3, rdata: 8'h00});
    exp_tx.push_back(ACK);
    send_byte(8'h57); send_byte(8'h12); send_byte(8'h34); send_byte(8'hA5);
    tests++;
    if (dbg.bus_req !== 1'b1 || dbg.bus_we !== 1'b1) begin
      fails++;
      $display("FAIL write_req_latency: bus_req=%b bus_we=%b, want 1 1", dbg.bus_req, dbg.bus_we);
    end
    drain("write");
  endtask

  task automatic test_read();
    exp_bus.push_back('{addr: 16'hFE03, we: 1'b0, wdata: 8'h00, delay: 0, rdata: 8'h5C});
    exp_tx.push_back(8'h5C);
    send_byte(8'h52); send_byte(8'hFE); send_byte(8'h03);
    tests++;
    if (dbg.bus_req !== 1'b1 || dbg.bus_we !== 1'b0) begin
      fails++;
      $display("FAIL read_req_latency: bus_req=%b bus_we=%b, want 1 0", dbg.bus_req, dbg.bus_we);
    end
    drain("read");
  endtask

  task automatic test_halt_go();
    dbg.tx_data_ready = 1'b0;
    exp_tx.push_back(ACK);
    send_byte(8'h48);
    tests++;
    if (dbg.cpu_halt !== 1'b1 || dbg.tx_data_valid !== 1'b1) begin
      fails++;
      $display("FAIL halt_set: cpu_halt=%b tx_data_valid=%b, want 1 1", dbg.cpu_halt, dbg.tx_data_valid);
    end
    repeat (10) @(posedge clk);
    #1;
    tests++;
    if (dbg.tx_data_valid !== 1'b1 || dbg.tx_data !== ACK) begin
      fails++;
      $display("FAIL halt_hold: tx_data_valid=%b tx_data=%h, want 1 2e", dbg.tx_data_valid, dbg.tx_data);
    end
    dbg.tx_data_ready = 1'b1;
    drain("halt");
    exp_tx.push_back(ACK);
    send_byte(8'h47);
    tests++;
    if (dbg.cpu_halt !== 1'b0 || dbg.tx_data_valid !== 1'b1) begin
      fails++;
      $display("FAIL go_clear: cpu_halt=%b tx_data_valid=%b, want 0 1", dbg.cpu_halt, dbg.tx_data_valid);
    end
    drain("go");
  endtask

  task automatic test_unknown_overrun();
    dbg.tx_data_ready = 1'b0;
    exp_tx.push_back(NAK);
    send_byte(8'h00);
    tests++;
    if (dbg.rx_overrun !== 1'b0 || dbg.tx_data_valid !== 1'b1) begin
      fails++;
      $display("FAIL unknown_resp: rx_overrun=%b tx_data_valid=%b, want 0 1", dbg.rx_overrun, dbg.tx_data_valid);
    end
    send_byte(8'h55);
    tests++;
    if (dbg.rx_overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set: rx_overrun=%b, want 1", dbg.rx_overrun);
    end
    dbg.tx_data_ready = 1'b1;
    drain("unknown");
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (dbg.tx_data_valid !== 1'b0 || dbg.rx_overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_drop: tx_data_valid=%b rx_overrun=%b, want 0 1", dbg.tx_data_valid, dbg.rx_overrun);
    end
  endtask

  task automatic test_timeout();
    send_byte(8'h57); send_byte(8'h12);
    repeat (20) @(posedge clk);
    #1;
    exp_bus.push_back('{addr: 16'h0010, we: 1'b0, wdata: 8'h00, delay: 1, rdata: 8'h9A});
    exp_tx.push_back(8'h9A);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
    drain("timeout");
  endtask

  task automatic test_timeout_edge();
    // Byte lands exactly on the last allowed cycle of the gap.
    send_byte(8'h57); send_byte(8'hAB);
    repeat (15) @(posedge clk);
    #1;
    exp_bus.push_back('{addr: 16'hABCD, we: 1'b1, wdata: 8'h77, delay: 2, rdata: 8'h00});
    exp_tx.push_back(ACK);
    send_byte(8'hCD); send_byte(8'h77);
    drain("timeout_edge");
  endtask

  task automatic test_reset_mid();
    exp_bus.push_back('{addr: 16'h0020, we: 1'b0, wdata: 8'h00, delay: 1000, rdata: 8'h00});
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h20);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (dbg.bus_req !== 1'b0 || dbg.tx_data_valid !== 1'b0 || dbg.rx_overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: bus_req=%b tx_data_valid=%b rx_overrun=%b, want 0 0 0", dbg.bus_req, dbg.tx_data_valid, dbg.rx_overrun);
    end
    exp_bus.delete();
    exp_tx.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    tests++;
    if (dbg.bus_req !== 1'b0 || dbg.tx_data_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: bus_req=%b tx_data_valid=%b, want 0 0", dbg.bus_req, dbg.tx_data_valid);
    end
    exp_tx.push_back(ACK);
    send_byte(8'h48);
    tests++;
    if (dbg.cpu_halt !== 1'b1 || dbg.tx_data_valid !== 1'b1) begin
      fails++;
      $display("FAIL reset_idle: cpu_halt=%b tx_data_valid=%b, want 1 1", dbg.cpu_halt, dbg.tx_data_valid);
    end
    drain("reset_idle");
  endtask

  initial begin
    dbg.rx_data = 8'h00;
    dbg.rx_data_valid = 1'b0;
    dbg.tx_data_ready = 1'b1;
    dbg.bus_rdata = 8'h00;
    dbg.bus_ack = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_halt_go();
    test_unknown_overrun();
    test_timeout();
    test_timeout_edge();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
